// File: rtl/muldiv_seq_pkg.sv
// Shared op encoding and sequencer types for the iterative multiply/divide unit.
package muldiv_seq_pkg;

    localparam int MD_XLEN = 64;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU,
        ALU_MUL,
        ALU_DIV,
        ALU_DIVU,
        ALU_REM,
        ALU_REMU
    } alu_ctr_t;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_CALC,
        MD_DONE
    } md_state_t;

    function automatic logic is_div_op(input alu_ctr_t op);
        return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the execute stage and the mul/div sequencer.
interface muldiv_seq_if
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) ();

    logic            flush;
    logic            in_valid;
    logic            in_ready;
    alu_ctr_t        op;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output flush, in_valid, op, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  flush, in_valid, op, src_a, src_b, out_ready,
        output in_ready, out_valid, result, busy
    );

endinterface

// File: rtl/muldiv_iter.sv
// One combinational step: shift-add multiply or restoring-divide subtract.
module muldiv_iter #(
    parameter int XLEN = 64
) (
    input  logic            is_div,
    input  logic [XLEN:0]   acc,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN:0]   acc_nx,
    output logic [XLEN-1:0] a_nx,
    output logic [XLEN-1:0] b_nx
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Divide: a shifts dividend bits out the top and quotient bits in the bottom.
    always_comb begin
        shifted = {acc[XLEN-1:0], a[XLEN-1]};
        diff    = shifted - {1'b0, b};
        acc_nx  = acc;
        a_nx    = a;
        b_nx    = b;
        if (is_div) begin
            if (!diff[XLEN]) begin
                acc_nx = diff;
                a_nx   = {a[XLEN-2:0], 1'b1};
            end else begin
                acc_nx = shifted;
                a_nx   = {a[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_nx = {1'b0, acc[XLEN-1:0] + (b[0] ? a : '0)};
            a_nx   = a << 1;
            b_nx   = b >> 1;
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MUL/DIV/DIVU/REM/REMU sequencer with valid/ready result handshake.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter  int XLEN  = MD_XLEN,
    localparam int CNT_W = $clog2(XLEN) + 1
) (
    input logic         clk,
    input logic         reset,
    muldiv_seq_if.slave md
);

    md_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN:0]   acc;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] res_q;
    logic            div_q;
    logic            rem_q;
    logic            neg_q;
    logic            neg_r;

    logic [XLEN:0]   acc_nx;
    logic [XLEN-1:0] a_nx;
    logic [XLEN-1:0] b_nx;

    logic            is_div;
    logic            is_sgn;
    logic            is_rem;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            div_zero;
    logic            ovf;
    logic [XLEN-1:0] spec_res;
    logic [XLEN-1:0] rem_v;
    logic [XLEN-1:0] fin_res;

    muldiv_iter #(.XLEN(XLEN)) u_iter (
        .is_div (div_q),
        .acc    (acc),
        .a      (a_q),
        .b      (b_q),
        .acc_nx (acc_nx),
        .a_nx   (a_nx),
        .b_nx   (b_nx)
    );

    always_comb begin
        is_div   = is_div_op(md.op);
        is_sgn   = md.op inside {ALU_DIV, ALU_REM};
        is_rem   = md.op inside {ALU_REM, ALU_REMU};
        a_neg    = is_sgn & md.src_a[XLEN-1];
        b_neg    = is_sgn & md.src_b[XLEN-1];
        abs_a    = a_neg ? -md.src_a : md.src_a;
        abs_b    = b_neg ? -md.src_b : md.src_b;
        div_zero = is_div && (md.src_b == '0);
        ovf      = is_sgn && (md.src_a == {1'b1, {(XLEN-1){1'b0}}})
                   && (md.src_b == '1);
        spec_res = div_zero ? (is_rem ? md.src_a : '1)
                            : (is_rem ? '0 : md.src_a);
    end

    // Sign fix uses this cycle's step output so DONE holds the final value.
    always_comb begin
        rem_v   = acc_nx[XLEN-1:0];
        fin_res = rem_v;
        unique case (1'b1)
            !div_q:  fin_res = rem_v;
            rem_q:   fin_res = neg_r ? -rem_v : rem_v;
            default: fin_res = neg_q ? -a_nx : a_nx;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= MD_IDLE;
            cnt   <= '0;
            acc   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            div_q <= 1'b0;
            rem_q <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (md.flush) begin
            state <= MD_IDLE;
        end else begin
            unique case (state)
                MD_IDLE: begin
                    if (md.in_valid) begin
                        div_q <= is_div;
                        rem_q <= is_rem;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        cnt   <= '0;
                        acc   <= '0;
                        a_q   <= is_div ? abs_a : md.src_a;
                        b_q   <= is_div ? abs_b : md.src_b;
                        if (div_zero || ovf) begin
                            res_q <= spec_res;
                            state <= MD_DONE;
                        end else begin
                            state <= MD_CALC;
                        end
                    end
                end
                MD_CALC: begin
                    acc <= acc_nx;
                    a_q <= a_nx;
                    b_q <= b_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(XLEN - 1)) begin
                        res_q <= fin_res;
                        state <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    if (md.out_ready) state <= MD_IDLE;
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

    assign md.in_ready  = (state == MD_IDLE);
    assign md.out_valid = (state == MD_DONE);
    assign md.busy      = (state != MD_IDLE);
    assign md.result    = res_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomised bench for muldiv_seq against a plain-arithmetic reference.
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    muldiv_seq_if bus ();

    muldiv_seq dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_res(alu_ctr_t o, logic [63:0] a,
                                            logic [63:0] b);
        longint sa;
        longint sb;
        sa = a;
        sb = b;
        case (o)
            ALU_DIV: begin
                if (b == 0) return '1;
                if (a == MIN64 && b == '1) return a;
                return sa / sb;
            end
            ALU_REM: begin
                if (b == 0) return a;
                if (a == MIN64 && b == '1) return '0;
                return sa % sb;
            end
            ALU_DIVU: return (b == 0) ? '1 : a / b;
            ALU_REMU: return (b == 0) ? a : a % b;
            default:  return a * b;
        endcase
    endfunction

    function automatic int ref_lat(alu_ctr_t o, logic [63:0] a,
                                   logic [63:0] b);
        if ((o == ALU_DIV || o == ALU_DIVU || o == ALU_REM || o == ALU_REMU)
            && b == 0) return 1;
        if ((o == ALU_DIV || o == ALU_REM) && a == MIN64 && b == '1)
            return 1;
        return 65;
    endfunction

    task automatic start_op(alu_ctr_t o, logic [63:0] a, logic [63:0] b);
        @(negedge clk);
        bus.op       = o;
        bus.src_a    = a;
        bus.src_b    = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 200);
    endtask

    task automatic run_op(alu_ctr_t o, logic [63:0] a, logic [63:0] b,
                          output logic [63:0] res, output int lat);
        start_op(o, a, b);
        wait_done(lat);
        res = bus.result;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0
            || bus.busy !== 1'b0 || bus.result !== 64'h0) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b busy=%b res=%h want 1 0 0 0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.result);
        end
    endtask

    task automatic check_op(string name, alu_ctr_t o, logic [63:0] a,
                            logic [63:0] b);
        logic [63:0] res;
        logic [63:0] exp;
        int          lat;
        int          elat;
        exp  = ref_res(o, a, b);
        elat = ref_lat(o, a, b);
        run_op(o, a, b, res, lat);
        checks++;
        if (res !== exp) begin
            errors++;
            $display("FAIL %s result: got %h want %h (op %s a %h b %h)",
                     name, res, exp, o.name(), a, b);
        end
        checks++;
        if (lat !== elat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, elat);
        end
    endtask

    task automatic test_directed();
        check_op("mul_7x-3", ALU_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
        check_op("div_-7/2", ALU_DIV, -64'sd7, 64'd2);
        check_op("rem_-7/2", ALU_REM, -64'sd7, 64'd2);
        check_op("divu_100/7", ALU_DIVU, 64'd100, 64'd7);
        check_op("remu_100/7", ALU_REMU, 64'd100, 64'd7);
    endtask

    task automatic test_special();
        check_op("divu_5/0", ALU_DIVU, 64'd5, 64'd0);
        check_op("rem_5/0", ALU_REM, 64'd5, 64'd0);
        check_op("div_ovf", ALU_DIV, MIN64, '1);
        check_op("rem_ovf", ALU_REM, MIN64, '1);
        check_op("divu_min/-1", ALU_DIVU, MIN64, '1);
    endtask

    task automatic test_random();
        alu_ctr_t    ops[6];
        logic [63:0] a;
        logic [63:0] b;
        ops = '{ALU_MUL, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU, ALU_ADD};
        for (int i = 0; i < 40; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0: b = 64'($urandom_range(0, 15));
                1: a = 64'($urandom_range(0, 1000));
                2: b = -64'($urandom_range(1, 9));
                3: a = -64'($urandom_range(1, 1000));
                default: ;
            endcase
            check_op("random", ops[$urandom_range(0, 5)], a, b);
        end
    endtask

    task automatic test_flush();
        int highs;
        start_op(ALU_MUL, 64'd123, 64'd456);
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_calc: rdy=%b busy=%b want 1 0",
                     bus.in_ready, bus.busy);
        end
        highs = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus.out_valid) highs++;
        end
        checks++;
        if (highs !== 0) begin
            errors++;
            $display("FAIL flush_novalid: out_valid high %0d cycles want 0",
                     highs);
        end
        check_op("mul_3x4", ALU_MUL, 64'd3, 64'd4);
        @(negedge clk);
        bus.op       = ALU_DIVU;
        bus.src_a    = 64'd9;
        bus.src_b    = 64'd0;
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: rdy=%b vld=%b want 1 0",
                     bus.in_ready, bus.out_valid);
        end
        start_op(ALU_DIVU, 64'd9, 64'd0);
        @(negedge clk);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_done: rdy=%b vld=%b want 1 0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_hold();
        logic [63:0] exp;
        int          lat;
        int          bad;
        exp = ref_res(ALU_REMU, 64'd1000, 64'd33);
        start_op(ALU_REMU, 64'd1000, 64'd33);
        wait_done(lat);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = 1'b1;
            bus.op       = ALU_MUL;
            bus.src_a    = {$urandom, $urandom};
            bus.src_b    = {$urandom, $urandom};
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.result !== exp
                || bus.busy !== 1'b1 || bus.in_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL hold: %0d bad cycles, result %h want %h",
                     bad, bus.result, exp);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: rdy=%b vld=%b want 1 0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp;
        int          lat;
        exp = ref_res(ALU_DIV, 64'd77, 64'd5);
        start_op(ALU_DIV, 64'd1, 64'd0);
        wait_done(lat);
        bus.op        = ALU_DIV;
        bus.src_a     = 64'd77;
        bus.src_b     = 64'd5;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle: in_ready=%b want 1", bus.in_ready);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        wait_done(lat);
        checks++;
        if (bus.result !== exp || lat !== 65) begin
            errors++;
            $display("FAIL b2b_op: got %h lat %0d want %h lat 65",
                     bus.result, lat, exp);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int highs;
        start_op(ALU_MUL, 64'd99, 64'd99);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0
            || bus.busy !== 1'b0 || bus.result !== 64'h0) begin
            errors++;
            $display("FAIL reset_mid: rdy=%b vld=%b busy=%b res=%h want 1 0 0 0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.result);
        end
        highs = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus.out_valid) highs++;
        end
        checks++;
        if (highs !== 0) begin
            errors++;
            $display("FAIL reset_novalid: out_valid high %0d cycles", highs);
        end
        check_op("after_reset", ALU_REM, 64'd1234567, -64'sd1000);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = ALU_MUL;
        bus.src_a     = '0;
        bus.src_b     = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_special();
        test_random();
        test_flush();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
